vga_sync: RTL and testbench

Raster timing generator for the 640x480 @ 60 Hz VGA display in the Pong design. Free-running horizontal and vertical counters produce the pixel coordinates (x, y), the visible-area flag and frame/line strobes that drive the game objects (ball, paddles, score). The generator also registers the merged object colour into a one-stage pixel pipeline. It re-times hsync/vsync to match, so the pins see colour and sync aligned.

---
 rtl/vga_sync.sv | 103 ++++++++++
 tb/tb_vga_sync.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// Raster timing generator for a 640x480@60 VGA display: pixel/line counters,
// visible-area and strobe flags, and a one-stage colour/sync pin pipeline.
module vga_sync #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk25M,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       vga_on,
    output logic       line_tick,
    output logic       frame_tick,
    input  logic [2:0] rgb_in,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [2:0] vga_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Counters are 10 bits wide, so larger totals cannot be represented.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_sync: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    logic       x_wrap_s;
    logic [9:0] x_nxt_s;
    logic [9:0] y_nxt_s;
    logic       hs0_r;
    logic       vs0_r;

    // Next counter values; y advances only on the x wrap.
    always_comb begin
        x_wrap_s = (x == H_LAST);
        x_nxt_s  = x + 10'd1;
        y_nxt_s  = y;
        if (x_wrap_s) begin
            x_nxt_s = 10'd0;
            if (y == V_LAST) begin
                y_nxt_s = 10'd0;
            end else begin
                y_nxt_s = y + 10'd1;
            end
        end else begin
            y_nxt_s = y;
        end
    end

    // Stage 0: counters and every flag decoded from the next counter values,
    // so all stage-0 outputs change together on the same edge.
    always_ff @(posedge clk25M) begin
        if (reset) begin
            x          <= 10'd0;
            y          <= 10'd0;
            vga_on     <= 1'b1;
            line_tick  <= 1'b1;
            frame_tick <= 1'b0;
            hs0_r      <= 1'b1;
            vs0_r      <= 1'b1;
        end else begin
            x          <= x_nxt_s;
            y          <= y_nxt_s;
            vga_on     <= (x_nxt_s < H_VIS) && (y_nxt_s < V_VIS);
            line_tick  <= (x_nxt_s == 10'd0);
            frame_tick <= (x_nxt_s == 10'd0) && (y_nxt_s == V_VIS);
            hs0_r      <= !((x_nxt_s >= H_SYNC_BEG) && (x_nxt_s < H_SYNC_END));
            vs0_r      <= !((y_nxt_s >= V_SYNC_BEG) && (y_nxt_s < V_SYNC_END));
        end
    end

    // Stage 1: colour (blanked outside the visible area) and syncs to the pins.
    always_ff @(posedge clk25M) begin
        if (reset) begin
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
            vga_rgb <= 3'b000;
        end else begin
            vga_hs  <= hs0_r;
            vga_vs  <= vs0_r;
            vga_rgb <= vga_on ? rgb_in : 3'b000;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a full-size instance and a reduced-timing instance,
// both compared every cycle against a position-based raster model.
module tb_vga_sync;

    logic clk25M = 1'b0;
    logic reset  = 1'b1;
    logic [2:0] rgb_in = 3'b000;

    int total = 0;
    int bad   = 0;

    always #20 clk25M = ~clk25M;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic d_on, d_lt, d_ft, d_hs, d_vs, s_on, s_lt, s_ft, s_hs, s_vs;
    logic [2:0] d_rgb, s_rgb;

    vga_sync dut (
        .clk25M(clk25M), .reset(reset), .x(d_x), .y(d_y), .vga_on(d_on),
        .line_tick(d_lt), .frame_tick(d_ft), .rgb_in(rgb_in),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_rgb(d_rgb)
    );

    vga_sync #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_s (
        .clk25M(clk25M), .reset(reset), .x(s_x), .y(s_y), .vga_on(s_on),
        .line_tick(s_lt), .frame_tick(s_ft), .rgb_in(rgb_in),
        .vga_hs(s_hs), .vga_vs(s_vs), .vga_rgb(s_rgb)
    );

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stage-0 view of the raster p clocks after reset:
    // {x[24:15], y[14:5], on[4], line_tick[3], frame_tick[2], hs0[1], vs0[0]}
    function automatic logic [24:0] stage0(input int p, input int ha, input int hfp,
                                           input int hsy, input int hbp, input int va,
                                           input int vfp, input int vsy, input int vbp);
        int ht = ha + hfp + hsy + hbp;
        int vt = va + vfp + vsy + vbp;
        int xx = p % ht;
        int yy = (p / ht) % vt;
        logic on  = (xx < ha) && (yy < va);
        logic lt  = (xx == 0);
        logic ft  = (xx == 0) && (yy == va);
        logic hs0 = !((xx >= ha + hfp) && (xx < ha + hfp + hsy));
        logic vs0 = !((yy >= va + vfp) && (yy < va + vfp + vsy));
        return {10'(xx), 10'(yy), on, lt, ft, hs0, vs0};
    endfunction

    int pd = 0;
    int ps = 0;
    logic mvalid = 1'b0;
    logic [4:0] e1d = 5'b11000;
    logic [4:0] e1s = 5'b11000;
    logic [24:0] s0d, s0s;

    assign s0d = stage0(pd, 640, 16, 96, 48, 480, 10, 2, 33);
    assign s0s = stage0(ps, 16, 4, 6, 6, 12, 2, 2, 3);

    // Model advance: position since reset, plus the one-clock pin stage.
    always @(posedge clk25M) begin
        if (reset) begin
            pd     <= 0;
            ps     <= 0;
            e1d    <= 5'b11000;
            e1s    <= 5'b11000;
            mvalid <= 1'b1;
        end else begin
            pd  <= pd + 1;
            ps  <= ps + 1;
            e1d <= {s0d[1], s0d[0], s0d[4] ? rgb_in : 3'b000};
            e1s <= {s0s[1], s0s[0], s0s[4] ? rgb_in : 3'b000};
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk25M) begin
        if (mvalid) begin
            check("full_raster", {d_x, d_y, d_on, d_lt, d_ft, d_hs, d_vs, d_rgb}, {s0d[24:2], e1d});
            check("small_raster", {s_x, s_y, s_on, s_lt, s_ft, s_hs, s_vs, s_rgb}, {s0s[24:2], e1s});
        end
    end

    int fall1 = 0, rise1 = 0, fall2 = 0;
    int lt_cnt = 0, ft_cnt = 0;
    logic prev_hs;

    initial begin
        reset  = 1'b1;
        rgb_in = 3'b101;
        repeat (2) @(posedge clk25M);
        #1;
        check("rst_x", 28'(d_x), 28'd0);
        check("rst_y", 28'(d_y), 28'd0);
        check("rst_flags", 28'({d_on, d_lt, d_ft, d_hs, d_vs}), 28'h1B);
        check("rst_rgb", 28'(d_rgb), 28'd0);
        check("rst_small", 28'({s_x, s_y, s_on, s_lt, s_ft}), 28'({10'd0, 10'd0, 3'b110}));
        reset   = 1'b0;
        prev_hs = d_hs;

        // Line timing on the full instance, strobe counts over two small frames.
        for (int k = 1; k <= 1500; k++) begin
            @(posedge clk25M);
            #1;
            rgb_in = 3'($urandom_range(0, 7));
            if (k == 1) check("first_x", 28'(d_x), 28'd1);
            if (prev_hs && !d_hs && fall1 == 0) fall1 = k;
            else if (prev_hs && !d_hs && fall2 == 0) fall2 = k;
            if (!prev_hs && d_hs && rise1 == 0) rise1 = k;
            prev_hs = d_hs;
            if (k <= 1216) begin
                lt_cnt += int'(s_lt);
                ft_cnt += int'(s_ft);
            end
        end
        check("hs_fall", 28'(fall1), 28'd657);
        check("hs_low_width", 28'(rise1 - fall1), 28'd96);
        check("hs_period", 28'(fall2 - fall1), 28'd800);
        check("line_ticks", 28'(lt_cnt), 28'd38);
        check("frame_ticks", 28'(ft_cnt), 28'd2);

        // Random colour with occasional reset pulses.
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk25M);
            #1;
            rgb_in = 3'($urandom_range(0, 7));
            reset  = ($urandom_range(0, 2999) == 0);
        end

        // Deterministic mid-frame reset pulse.
        reset = 1'b0;
        repeat (700) @(posedge clk25M);
        #1;
        reset = 1'b1;
        @(posedge clk25M);
        #1;
        reset = 1'b0;
        check("midrst_xy", 28'({d_x, d_y}), 28'd0);
        check("midrst_pins", 28'({d_on, d_hs, d_vs, d_rgb}), 28'h38);
        @(posedge clk25M);
        #1;
        check("midrst_resume", 28'(d_x), 28'd1);
        repeat (50) @(posedge clk25M);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
